// File: rtl/peak_result_streamer.sv
// Snapshots the per-pixel peak array on a detector strobe and streams it one pixel per cycle.
// Optional frame header word is enabled by defining FRAME_HEADER_EN.
module peak_result_streamer #(
  parameter int NP        = 16,
  parameter int PIXEL_NUM = 200,
  parameter int FRAME_W   = 16,
  parameter int OVR_W     = 8
) (
  input  logic                    clk,
  input  logic                    res,
  input  logic [NP*PIXEL_NUM-1:0] peak_in,
  input  logic                    peak_vld,
  output logic [NP-1:0]           out_data,
  output logic [7:0]              out_pixel,
  output logic                    out_hdr,
  output logic                    out_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    busy,
  output logic [FRAME_W-1:0]      frame_idx,
  output logic [OVR_W-1:0]        ovr_cnt,
  output logic                    ovr_flag
);

  localparam int IW = (PIXEL_NUM > 1) ? $clog2(PIXEL_NUM) : 1;
  localparam logic [7:0] LAST = 8'(PIXEL_NUM - 1);

  typedef enum logic [1:0] {IDLE, HDR, STREAM} state_t;

  state_t                           state;
  logic [7:0]                       ptr;
  logic [PIXEL_NUM-1:0][NP-1:0]     bank;
  logic                             xfer, fin, cap, ovr;
  logic [IW-1:0]                    nxt_idx;

  assign xfer    = out_valid && out_ready;
  assign fin     = (state == STREAM) && xfer && (ptr == LAST);
  // A capture on the final handshake chains frames with no idle gap.
  assign cap     = peak_vld && ((state == IDLE) || fin);
  assign ovr     = peak_vld && !cap;
  assign nxt_idx = IW'(ptr + 8'd1);

  assign busy      = (state != IDLE);
  assign out_pixel = ptr;

`ifdef FRAME_HEADER_EN
  logic [NP+FRAME_W-1:0] hdr_ext;
  assign hdr_ext = {{NP{1'b0}}, frame_idx};
`endif

  always_ff @(posedge clk) begin
    if (cap) bank <= peak_in;
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state     <= IDLE;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_hdr   <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      frame_idx <= '0;
      ovr_cnt   <= '0;
      ovr_flag  <= 1'b0;
    end else begin
      if (ovr) begin
        if (ovr_cnt != {OVR_W{1'b1}}) ovr_cnt <= ovr_cnt + 1'b1;
        ovr_flag <= 1'b1;
      end
      if (cap) begin
        frame_idx <= frame_idx + 1'b1;
        ptr       <= '0;
        out_valid <= 1'b1;
`ifdef FRAME_HEADER_EN
        state     <= HDR;
        out_hdr   <= 1'b1;
        out_last  <= 1'b0;
        out_data  <= hdr_ext[NP-1:0];
`else
        state     <= STREAM;
        out_hdr   <= 1'b0;
        out_last  <= (LAST == 8'd0);
        out_data  <= peak_in[NP-1:0];
`endif
      end else if (xfer) begin
        case (state)
          HDR: begin
            state    <= STREAM;
            ptr      <= '0;
            out_hdr  <= 1'b0;
            out_data <= bank[0];
            out_last <= (LAST == 8'd0);
          end
          STREAM: begin
            if (ptr == LAST) begin
              state     <= IDLE;
              ptr       <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_data  <= '0;
            end else begin
              ptr      <= ptr + 8'd1;
              out_data <= bank[nxt_idx];
              out_last <= ((ptr + 8'd1) == LAST);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_peak_result_streamer.sv
// Directed bench for peak_result_streamer with a frame-level queue model checked every cycle.
module tb_peak_result_streamer;
  localparam int NP = 16, PN = 4, FW = 16, OW = 2;
`ifdef FRAME_HEADER_EN
  localparam int HW = 1;
`else
  localparam int HW = 0;
`endif

  typedef struct {logic [15:0] d; logic [7:0] p; logic h; logic l;} w_t;

  logic clk = 0, res = 0, peak_vld = 0, out_ready = 1;
  logic [NP*PN-1:0] peak_in = '0;
  logic [NP-1:0] out_data;
  logic [7:0] out_pixel;
  logic out_hdr, out_last, out_valid, busy, ovr_flag;
  logic [FW-1:0] frame_idx;
  logic [OW-1:0] ovr_cnt;

  peak_result_streamer #(.NP(NP), .PIXEL_NUM(PN), .FRAME_W(FW), .OVR_W(OW)) dut (
    .clk(clk), .res(res), .peak_in(peak_in), .peak_vld(peak_vld),
    .out_data(out_data), .out_pixel(out_pixel), .out_hdr(out_hdr), .out_last(out_last),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .frame_idx(frame_idx), .ovr_cnt(ovr_cnt), .ovr_flag(ovr_flag));

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  bit chk_en = 0;
  w_t mq[$];
  w_t acc[$];
  logic [15:0] m_fidx;
  logic [OW-1:0] m_ovr;
  logic m_flag;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", n, a, e, $time);
    end
  endtask

  // Model: a frame is a list of words; a capture is only possible when nothing is queued.
  always @(posedge clk) begin
    if (res && out_valid && out_ready) acc.push_back('{out_data, out_pixel, out_hdr, out_last});
    if (!res) begin
      mq.delete(); m_fidx = '0; m_ovr = '0; m_flag = 0;
    end else begin
      if (mq.size() > 0 && out_ready) void'(mq.pop_front());
      if (peak_vld) begin
        if (mq.size() == 0) begin
          if (HW == 1) mq.push_back('{m_fidx, 8'd0, 1'b1, 1'b0});
          for (int k = 0; k < PN; k++)
            mq.push_back('{peak_in[k*NP +: NP], 8'(k), 1'b0, k == PN-1});
          m_fidx = m_fidx + 16'd1;
        end else begin
          if (m_ovr != {OW{1'b1}}) m_ovr = m_ovr + 1'b1;
          m_flag = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("valid", 32'(out_valid), 32'(mq.size() > 0));
      chk("busy", 32'(busy), 32'(mq.size() > 0));
      chk("frame_idx", 32'(frame_idx), 32'(m_fidx));
      chk("ovr_cnt", 32'(ovr_cnt), 32'(m_ovr));
      chk("ovr_flag", 32'(ovr_flag), 32'(m_flag));
      if (mq.size() > 0) begin
        chk("data", 32'(out_data), 32'(mq[0].d));
        chk("pixel", 32'(out_pixel), 32'(mq[0].p));
        chk("hdr", 32'(out_hdr), 32'(mq[0].h));
        chk("last", 32'(out_last), 32'(mq[0].l));
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  function automatic logic [NP*PN-1:0] mk(logic [15:0] base);
    logic [NP*PN-1:0] v;
    for (int k = 0; k < PN; k++) v[k*NP +: NP] = base + 16'(k);
    return v;
  endfunction

  task automatic pulse(logic [15:0] base);
    peak_in = mk(base); peak_vld = 1; step(); peak_vld = 0;
  endtask

  // Literal expectations on the logged transfers for one frame.
  task automatic chk_frame(string n, int off, logic [15:0] base, logic [15:0] hv);
    if (HW == 1 && off < acc.size()) begin
      chk({n, "_hdr"}, 32'(acc[off].h), 32'd1);
      chk({n, "_hdat"}, 32'(acc[off].d), 32'(hv));
    end
    for (int i = 0; i < PN; i++) begin
      if (off + HW + i < acc.size()) begin
        chk({n, "_d"}, 32'(acc[off+HW+i].d), 32'(base + 16'(i)));
        chk({n, "_p"}, 32'(acc[off+HW+i].p), 32'(i));
        chk({n, "_l"}, 32'(acc[off+HW+i].l), 32'(i == PN-1));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(2);
    chk_en = 1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_pixel", 32'(out_pixel), 0);
    chk("rst_fidx", 32'(frame_idx), 0);
    res = 1;
    step();

    // basic stream
    acc.delete();
    pulse(16'h0001);
`ifdef FRAME_HEADER_EN
    chk("t1_first_hdr", 32'(out_hdr), 1);
    chk("t1_first_hdat", 32'(out_data), 0);
`else
    chk("t1_first_d", 32'(out_data), 32'h1);
    chk("t1_first_p", 32'(out_pixel), 0);
`endif
    step(PN + HW);
    chk("t1_busy", 32'(busy), 0);
    chk("t1_n", acc.size(), PN + HW);
    chk("t1_fidx", 32'(frame_idx), 1);
    chk_frame("t1", 0, 16'h0001, 16'd0);

    // backpressure 1,0,0,1,...
    acc.delete();
    pulse(16'h0011);
    for (int i = 0; i < 16; i++) begin
      out_ready = (i % 4 == 0) || (i % 4 == 3);
      step();
    end
    out_ready = 1;
    step(4);
    chk("t2_n", acc.size(), PN + HW);
    chk("t2_fidx", 32'(frame_idx), 2);
    chk_frame("t2", 0, 16'h0011, 16'd1);

    // overrun at ptr=1
    acc.delete();
    pulse(16'h0021);
    step(1 + HW);
    chk("t3_ptr", 32'(out_pixel), 1);
    peak_in = mk(16'h0031); peak_vld = 1; step(); peak_vld = 0;
    step(2);
    chk("t3_ovr", 32'(ovr_cnt), 1);
    chk("t3_flag", 32'(ovr_flag), 1);
    chk("t3_fidx", 32'(frame_idx), 3);
    chk("t3_n", acc.size(), PN + HW);
    chk_frame("t3", 0, 16'h0021, 16'd2);

    // back-to-back: capture on final handshake
    acc.delete();
    pulse(16'h0041);
    step(3 + HW);
    chk("t4_at_last", 32'(out_last), 1);
    peak_in = mk(16'h0051); peak_vld = 1; step(); peak_vld = 0;
    chk("t4_valid", 32'(out_valid), 1);
`ifdef FRAME_HEADER_EN
    chk("t4_hdr", 32'(out_hdr), 1);
    chk("t4_hdat", 32'(out_data), 4);
`else
    chk("t4_d0", 32'(out_data), 32'h51);
    chk("t4_p0", 32'(out_pixel), 0);
`endif
    chk("t4_ovr", 32'(ovr_cnt), 1);
    chk("t4_fidx", 32'(frame_idx), 5);
    step(PN + HW);
    chk("t4_n", acc.size(), 2 * (PN + HW));
    chk_frame("t4a", 0, 16'h0041, 16'd3);
    chk_frame("t4b", PN + HW, 16'h0051, 16'd4);

    // reset mid-stream at ptr=2
    pulse(16'h0061);
    step(2 + HW);
    chk("t5_ptr", 32'(out_pixel), 2);
    res = 0; step(); res = 1;
    chk("t5_valid", 32'(out_valid), 0);
    chk("t5_fidx", 32'(frame_idx), 0);
    chk("t5_ovr", 32'(ovr_cnt), 0);
    chk("t5_flag", 32'(ovr_flag), 0);
    acc.delete();
    pulse(16'h0071);
    step(PN + HW);
    chk("t5_n", acc.size(), PN + HW);
    chk_frame("t5", 0, 16'h0071, 16'd0);

    // further frames; the third after reset carries header index 2
    acc.delete();
    pulse(16'h0081);
    step(PN + HW);
    pulse(16'h0091);
`ifdef FRAME_HEADER_EN
    chk("t6_hdr", 32'(out_hdr), 1);
    chk("t6_hdat", 32'(out_data), 2);
`endif
    step(PN + HW);
    chk_frame("t6a", 0, 16'h0081, 16'd1);
    chk_frame("t6b", PN + HW, 16'h0091, 16'd2);

    // overrun counter saturation while stalled
    acc.delete();
    pulse(16'h00a1);
    out_ready = 0; peak_vld = 1;
    step(5);
    peak_vld = 0; out_ready = 1;
    step(PN + HW);
    chk("t7_ovr_sat", 32'(ovr_cnt), 3);
    chk("t7_flag", 32'(ovr_flag), 1);
    chk("t7_fidx", 32'(frame_idx), 4);
    chk_frame("t7", 0, 16'h00a1, 16'd3);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
